// File: rtl/register_bank_pkg.sv
// Shared definitions for register_bank: write/count operation encoding and
// the decoder that applies latch > (inc xor dec) priority.
package register_bank_pkg;

  localparam logic [1:0] OP_HOLD = 2'd0;
  localparam logic [1:0] OP_LOAD = 2'd1;
  localparam logic [1:0] OP_INC  = 2'd2;
  localparam logic [1:0] OP_DEC  = 2'd3;

  // latch wins; inc and dec together cancel into a hold
  function automatic logic [1:0] decode_op(input logic latch, input logic inc, input logic dec);
    if (latch)
      return OP_LOAD;
    else if (inc && !dec)
      return OP_INC;
    else if (dec && !inc)
      return OP_DEC;
    else
      return OP_HOLD;
  endfunction

endpackage

// File: rtl/register_bank_cell.sv
// One register of the bank. Applies the decoded op when selected and reports
// whether that op crosses the wrap boundary (all ones on inc, zero on dec).
// Optional build macro: REGISTER_BANK_SATURATE_EN (clamp instead of wrap).
module register_bank_cell
  import register_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] value,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [WIDTH-1:0] next_value;

  // boundary detect for the op about to be applied
  always_comb begin
    wrap = ((op == OP_INC) && (value == ALL_ONES)) ||
           ((op == OP_DEC) && (value == '0));
  end

  // next register value for the decoded op
  always_comb begin
    next_value = value;
    case (op)
      OP_LOAD: next_value = data_in;
`ifdef REGISTER_BANK_SATURATE_EN
      OP_INC:  next_value = wrap ? value : value + WIDTH'(1);
      OP_DEC:  next_value = wrap ? value : value - WIDTH'(1);
`else
      OP_INC:  next_value = value + WIDTH'(1);
      OP_DEC:  next_value = value - WIDTH'(1);
`endif
      default: next_value = value;
    endcase
  end

  // register state; only the selected cell updates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      value <= '0;
    else if (sel)
      value <= next_value;
  end

endmodule

// File: rtl/register_bank.sv
// register_bank: DEPTH x WIDTH register file with one load/inc/dec port,
// one tristate read port, combinational zero flag and registered carry flag.
// Optional build macro: REGISTER_BANK_SATURATE_EN (inc/dec saturate).
module register_bank
  import register_bank_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  data_in,
  output logic [WIDTH-1:0]  data_out,
  input  logic              out_enable,
  input  logic [ADDR_W-1:0] out_sel,
  input  logic [ADDR_W-1:0] wr_sel,
  input  logic              latch,
  input  logic              inc,
  input  logic              dec,
  output logic              zero,
  output logic              carry
);

  logic [1:0]       op;
  logic [WIDTH-1:0] values [DEPTH];
  logic [DEPTH-1:0] wraps;
  logic [WIDTH-1:0] rd_value;
  logic [WIDTH-1:0] wr_value;
  logic             wr_wrap;
  logic             wr_valid;

  assign op = decode_op(latch, inc, dec);

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    register_bank_cell #(
      .WIDTH(WIDTH)
    ) u_cell (
      .clk    (clk),
      .rst_n  (rst_n),
      .sel    (wr_sel == ADDR_W'(i)),
      .op     (op),
      .data_in(data_in),
      .value  (values[i]),
      .wrap   (wraps[i])
    );
  end

  // read mux and write-target lookup; out-of-range selects yield zero/invalid
  always_comb begin
    rd_value = '0;
    wr_value = '0;
    wr_wrap  = 1'b0;
    wr_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (out_sel == ADDR_W'(i))
        rd_value = values[i];
      if (wr_sel == ADDR_W'(i)) begin
        wr_value = values[i];
        wr_wrap  = wraps[i];
        wr_valid = 1'b1;
      end
    end
  end

  assign zero     = wr_valid && (wr_value == '0);
  assign data_out = out_enable ? rd_value : 'z;

  // carry updates on any requested operation, holds when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      carry <= 1'b0;
    else if (latch || inc || dec)
      carry <= wr_valid && wr_wrap;
  end

endmodule
